ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
- Receives PS/2 keyboard frames from the Basys3 USB-HID PS/2 pins.
- Recovers 8-bit Set-2 scan codes and filters out break (release), extended (E0) and typematic-repeat traffic.
- Emits one qualified make code per physical keypress.
- Feeds the scan-code-to-letter-index decoder directly downstream, so each keystroke advances the Enigma path exactly once.

Parameters:
- FILTER_LEN, 8: cycles ps2_clk must be stable before the filtered level changes (glitch filter).
- TIMEOUT_CYC, 50000: system cycles without a filtered ps2_clk falling edge before a partial frame is aborted (500 us at 100 MHz).
- SUPPRESS_REPEAT, 1: 1 = drop auto-repeat make codes until the key is released; 0 = pass them through.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk
- code  out  8  last accepted make code; held until the next accepted code
- code_valid  out  1  one-cycle strobe: code is newly updated
- frame_err  out  1  one-cycle strobe on a parity, stop-bit or timeout error
- busy  out  1  high while a frame is in progress (receiver not in IDLE)

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0, code = 8'h00, both FSMs IDLE/NORMAL, repeat tracker cleared (no key held), synchronisers and filter loaded with 1.
- Input conditioning:
  - Both pins pass through a 2-flop synchroniser.
  - ps2_clk then passes through the FILTER_LEN stability filter.
  - fall_stb is a one-cycle strobe on each filtered 1->0 transition.
  - ps2_data is sampled from the synchronised value in the cycle fall_stb is high.
- Frame receiver FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: on fall_stb, data=0 goes to DATA with bit count 0; data=1 (bad start) stays IDLE with no error.
  - DATA: shifts 8 bits LSB first, then goes to PARITY.
  - PARITY: captures the parity bit.
  - STOP: on fall_stb the frame is complete and the FSM returns to IDLE.
  - A frame is good if stop=1 and XOR(data, parity)=1 (odd parity). A bad frame raises frame_err for one cycle and the byte is dropped.
- Timeout:
  - In any state other than IDLE, a counter counts cycles since the last fall_stb.
  - Reaching TIMEOUT_CYC returns the FSM to IDLE, pulses frame_err, and drops the partial byte.
  - The counter is held at 0 in IDLE.
- Byte decoder FSM (NORMAL, BREAK, EXT, EXT_BREAK), advanced only by good bytes:
  - NORMAL:
    - F0 goes to BREAK.
    - E0 goes to EXT.
    - Any other byte b is a make code: it is accepted unless SUPPRESS_REPEAT=1 and b equals the held code, in which case it is dropped. If accepted, it becomes the held code.
  - BREAK: byte b goes to NORMAL; if b equals the held code, the held code is cleared.
  - EXT: F0 goes to EXT_BREAK; anything else goes to NORMAL and is dropped.
  - EXT_BREAK: any byte goes to NORMAL and is dropped.
  - Extended keys never produce output and do not touch the held code.
- Latency: an accepted code is presented with code_valid high exactly 1 cycle after the fall_stb cycle that sampled its stop bit. Pin-to-fall_stb delay is 2 + FILTER_LEN cycles.
- code_valid and frame_err are never high together. Neither is asserted for prefix bytes (F0/E0).
- Error handling: a frame error does not change the decoder state. A subsequent good frame continues the prefix sequence.
- busy = (receiver state != IDLE).
- Reset mid-frame: everything is discarded, no strobe is issued, and the next start bit is received normally.

Test Plan:
- Send frame 0x1C (good parity=0, stop=1) -> code=8'h1C with code_valid pulsed once, 1 cycle after the stop-bit fall_stb; busy low afterwards.
- Send 1C, F0, 1C, 1C -> exactly two code_valid pulses, both 8'h1C. The release clears the hold, so the second press is accepted.
- SUPPRESS_REPEAT=1, send 1C, 1C, 1C -> one pulse. With SUPPRESS_REPEAT=0 -> three pulses.
- Send E0 75, E0 F0 75, then 32 -> no pulse for the extended key; code=8'h32 pulsed once; code holds 8'h32 thereafter.
- Send 0x1C with the parity bit flipped -> frame_err one pulse, no code_valid, code unchanged. Send 0x1C with stop=0 -> same response.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, busy falls; a following good 0x24 yields code=8'h24. Separately, assert rst_n low mid-frame -> outputs 0, no strobe, and the next 0x24 is received correctly.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, frames 11-bit
// words, and turns Set-2 traffic into one qualified make code per keypress.
module ps2_scancode_rx #(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYC     = 50000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} dec_state_t;

  rx_state_t  rx_state;
  dec_state_t dec_state;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall_stb;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] tcnt;
  logic [7:0]    held;
  logic          held_vld;
  logic          frame_good;

  // Filtered level only flips after the synchronised pin has disagreed with it
  // for FILTER_LEN consecutive cycles; fall_stb marks the flip to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall_stb   = clk_filt && !clk_s2 && (flt_cnt == FW'(FILTER_LEN - 1));
  assign frame_good = dat_s2 && (^{shreg, parity_bit});
  assign busy       = (rx_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      dec_state  <= NORMAL;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tcnt       <= '0;
      held       <= '0;
      held_vld   <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (rx_state == IDLE || fall_stb) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (rx_state != IDLE && !fall_stb && tcnt == TW'(TIMEOUT_CYC - 1)) begin
        rx_state  <= IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (fall_stb) begin
        case (rx_state)
          IDLE: begin
            if (!dat_s2) begin
              rx_state <= DATA;
              bit_cnt  <= '0;
            end
          end
          DATA: begin
            shreg <= {dat_s2, shreg[7:1]};
            if (bit_cnt == 3'd7) rx_state <= PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            parity_bit <= dat_s2;
            rx_state   <= STOP;
          end
          STOP: begin
            rx_state <= IDLE;
            if (!frame_good) begin
              frame_err <= 1'b1;
            end else begin
              // Prefix bytes only steer the decoder; extended keys never emit.
              case (dec_state)
                NORMAL: begin
                  if (shreg == 8'hF0) begin
                    dec_state <= BREAK;
                  end else if (shreg == 8'hE0) begin
                    dec_state <= EXT;
                  end else if (!(SUPPRESS_REPEAT != 0 && held_vld && shreg == held)) begin
                    code       <= shreg;
                    code_valid <= 1'b1;
                    held       <= shreg;
                    held_vld   <= 1'b1;
                  end
                end
                BREAK: begin
                  dec_state <= NORMAL;
                  if (held_vld && shreg == held) begin
                    held     <= '0;
                    held_vld <= 1'b0;
                  end
                end
                EXT:       dec_state <= (shreg == 8'hF0) ? EXT_BREAK : NORMAL;
                EXT_BREAK: dec_state <= NORMAL;
                default:   dec_state <= NORMAL;
              endcase
            end
          end
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

endmodule
